// File: rtl/dft_sequencer.sv
// Phase controller for the direct-DFT datapath: sample load, cache fill, per-bin MAC, write-back.
// Optional build macro DFT_SEQ_PERF_EN adds the perf_cycles compute-cycle counter.
module dft_sequencer #(
  parameter int unsigned AW      = 12,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] samp_number,
  input  logic          data_loaded,
  input  logic          out_done,
  output logic          load_nCompute,
  output logic          cache_we,
  output logic [AW-1:0] n_index,
  output logic [AW-1:0] k_index,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          res_we,
  output logic          calc_end,
  output logic          busy,
  output logic          err_len
`ifdef DFT_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StFill  = 3'd2;
  localparam logic [2:0] StAclr  = 3'd3;
  localparam logic [2:0] StAcc   = 3'd4;
  localparam logic [2:0] StDrain = 3'd5;
  localparam logic [2:0] StWb    = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  localparam logic [2:0] DrainLast = (MAC_LAT == 0) ? 3'd0 : 3'(MAC_LAT - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] s_last_q, s_last_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] k_q, k_d;
  logic [2:0]    drain_q, drain_d;
  logic          err_q, err_d;
  logic          len_ok;
  logic          issue;

  assign len_ok = (samp_number >= AW'(2));

  always_comb begin
    state_d  = state_q;
    s_last_d = s_last_q;
    n_d      = n_q;
    k_d      = k_q;
    drain_d  = drain_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            // Store S-1 so every loop bound is a direct equality compare.
            s_last_d = samp_number - AW'(1);
            n_d      = '0;
            k_d      = '0;
            state_d  = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (data_loaded) begin
          n_d     = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (n_q == s_last_q) begin
          n_d     = '0;
          k_d     = '0;
          state_d = StAclr;
        end else begin
          n_d = n_q + AW'(1);
        end
      end
      StAclr: begin
        state_d = StAcc;
      end
      StAcc: begin
        if (n_q == s_last_q) begin
          drain_d = '0;
          state_d = (MAC_LAT == 0) ? StWb : StDrain;
        end else begin
          n_d = n_q + AW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StWb;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      StWb: begin
        if (k_q == s_last_q) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + AW'(1);
          n_d     = '0;
          state_d = StAclr;
        end
      end
      StDone: begin
        if (out_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      s_last_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_last_q <= s_last_d;
      n_q      <= n_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
    end
  end

  assign issue = (state_q == StAcc);

  // Valid tag travels alongside the MAC pipeline so acc_en lines up with each product.
  if (MAC_LAT == 0) begin : g_no_pipe
    assign acc_en = issue;
  end else begin : g_pipe
    logic [MAC_LAT-1:0] vld_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= issue;
        for (int i = 1; i < MAC_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end
    assign acc_en = vld_q[MAC_LAT-1];
  end

  assign load_nCompute = (state_q == StIdle) || (state_q == StLoad) || (state_q == StFill);
  assign cache_we      = (state_q == StFill);
  assign acc_clr       = (state_q == StAclr);
  assign res_we        = (state_q == StWb);
  assign calc_end      = (state_q == StDone);
  assign busy          = (state_q != StIdle);
  assign err_len       = err_q;
  assign n_index       = n_q;
  assign k_index       = k_q;

`ifdef DFT_SEQ_PERF_EN
  logic        accept;
  logic        in_compute;
  logic [31:0] perf_q;

  assign accept     = (state_q == StIdle) && start && len_ok;
  assign in_compute = (state_q == StAclr) || (state_q == StAcc) ||
                      (state_q == StDrain) || (state_q == StWb);

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_q <= '0;
    end else if (in_compute && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_dft_sequencer.sv
// Scoreboard bench for dft_sequencer: two instances (MAC_LAT=2 and MAC_LAT=0) share one monitor.
`timescale 1ns/1ps
module tb_dft_sequencer;
  localparam int AW = 12;

  typedef struct {
    int k;
    int gap;
  } res_t;

  typedef struct {
    int fill;
    int clr;
    int en;
    int res;
    int ce_len;
  } sum_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          data_loaded = 1'b0;
  logic          out_done = 1'b0;
  logic [AW-1:0] samp_number = '0;
  logic          sel = 1'b0;
  logic          a_start, b_start;

  logic          a_load, a_cache_we, a_acc_clr, a_acc_en, a_res_we, a_calc_end, a_busy, a_err;
  logic [AW-1:0] a_n, a_k;
  logic          b_load, b_cache_we, b_acc_clr, b_acc_en, b_res_we, b_calc_end, b_busy, b_err;
  logic [AW-1:0] b_n, b_k;
  logic          m_load, m_cache_we, m_acc_clr, m_acc_en, m_res_we, m_calc_end, m_busy, m_err;
  logic [AW-1:0] m_n, m_k;
`ifdef DFT_SEQ_PERF_EN
  logic [31:0]   a_perf, b_perf, m_perf;
`endif

  always #5 clk = ~clk;

  assign a_start = start && !sel;
  assign b_start = start && sel;

  dft_sequencer #(.AW(AW), .MAC_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .samp_number(samp_number),
    .data_loaded(data_loaded), .out_done(out_done), .load_nCompute(a_load),
    .cache_we(a_cache_we), .n_index(a_n), .k_index(a_k), .acc_clr(a_acc_clr),
    .acc_en(a_acc_en), .res_we(a_res_we), .calc_end(a_calc_end), .busy(a_busy),
    .err_len(a_err)
`ifdef DFT_SEQ_PERF_EN
    , .perf_cycles(a_perf)
`endif
  );

  dft_sequencer #(.AW(AW), .MAC_LAT(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .samp_number(samp_number),
    .data_loaded(data_loaded), .out_done(out_done), .load_nCompute(b_load),
    .cache_we(b_cache_we), .n_index(b_n), .k_index(b_k), .acc_clr(b_acc_clr),
    .acc_en(b_acc_en), .res_we(b_res_we), .calc_end(b_calc_end), .busy(b_busy),
    .err_len(b_err)
`ifdef DFT_SEQ_PERF_EN
    , .perf_cycles(b_perf)
`endif
  );

  assign m_load     = sel ? b_load     : a_load;
  assign m_cache_we = sel ? b_cache_we : a_cache_we;
  assign m_acc_clr  = sel ? b_acc_clr  : a_acc_clr;
  assign m_acc_en   = sel ? b_acc_en   : a_acc_en;
  assign m_res_we   = sel ? b_res_we   : a_res_we;
  assign m_calc_end = sel ? b_calc_end : a_calc_end;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_err      = sel ? b_err      : a_err;
  assign m_n        = sel ? b_n        : a_n;
  assign m_k        = sel ? b_k        : a_k;
`ifdef DFT_SEQ_PERF_EN
  assign m_perf     = sel ? b_perf     : a_perf;
`endif

  int n_checks = 0;
  int n_err = 0;

  int   exp_fill_q[$];
  res_t exp_res_q[$];
  sum_t exp_sum_q[$];
  int   exp_err_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the selected DUT presents an event.
  int   cyc = 0;
  int   n_fill, n_clr, n_en, n_res, clr_cyc, last_res, ce_len;
  bit   en_pend, ce_prev, err_prev, have_sum;
  res_t mr;
  sum_t cur_sum;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      n_fill = 0; n_clr = 0; n_en = 0; n_res = 0; ce_len = 0;
      en_pend = 0; ce_prev = 0; err_prev = 0; have_sum = 0; last_res = -1;
    end else begin
      if (m_cache_we) begin
        n_fill++;
        if (exp_fill_q.size() == 0) chk("fill_unexpected", 1, 0);
        else chk("fill_n_index", m_n, exp_fill_q.pop_front());
      end
      if (m_acc_clr) begin
        n_clr++;
        chk("clr_en_overlap", m_acc_en, 0);
        clr_cyc = cyc;
        en_pend = 1;
      end
      if (m_acc_en) begin
        n_en++;
        if (en_pend) begin
          chk("acc_en_latency", cyc - clr_cyc, sel ? 1 : 3);
          en_pend = 0;
        end
      end
      if (m_res_we) begin
        n_res++;
        chk("res_en_overlap", m_acc_en, 0);
        if (exp_res_q.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          mr = exp_res_q.pop_front();
          chk("res_k_index", m_k, mr.k);
          if (mr.gap != 0) chk("res_spacing", cyc - last_res, mr.gap);
        end
        last_res = cyc;
      end
      if (m_err) begin
        chk("err_expected", exp_err_q.size() != 0, 1);
        chk("err_width", err_prev, 0);
        chk("err_busy", m_busy, 0);
        if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
      end
      if (m_calc_end && !ce_prev) begin
        if (exp_sum_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          cur_sum = exp_sum_q.pop_front();
          have_sum = 1;
          chk("cache_we_count", n_fill, cur_sum.fill);
          chk("acc_clr_count", n_clr, cur_sum.clr);
          chk("acc_en_count", n_en, cur_sum.en);
          chk("res_we_count", n_res, cur_sum.res);
        end
        n_fill = 0; n_clr = 0; n_en = 0; n_res = 0; ce_len = 0;
      end
      if (m_calc_end) ce_len++;
      if (!m_calc_end && ce_prev && have_sum) begin
        chk("calc_end_len", ce_len, cur_sum.ce_len);
        have_sum = 0;
      end
      ce_prev  = m_calc_end;
      err_prev = m_err;
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_load_nCompute"}, m_load, 1);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_cache_we"}, m_cache_we, 0);
    chk({tag, "_acc_clr"}, m_acc_clr, 0);
    chk({tag, "_acc_en"}, m_acc_en, 0);
    chk({tag, "_res_we"}, m_res_we, 0);
    chk({tag, "_calc_end"}, m_calc_end, 0);
    chk({tag, "_err_len"}, m_err, 0);
    chk({tag, "_n_index"}, m_n, 0);
    chk({tag, "_k_index"}, m_k, 0);
  endtask

  task automatic do_run(input int s, input int ml, input int dl_delay, input int od_delay,
                        input bit noise);
    res_t r;
    sum_t sm;
    bit   seen;
    for (int i = 0; i < s; i++) exp_fill_q.push_back(i);
    for (int k = 0; k < s; k++) begin
      r.k   = k;
      r.gap = (k == 0) ? 0 : (s + ml + 2);
      exp_res_q.push_back(r);
    end
    sm.fill = s; sm.clr = s; sm.en = s * s; sm.res = s; sm.ce_len = od_delay + 1;
    exp_sum_q.push_back(sm);

    @(posedge clk); #1;
    start = 1'b1;
    samp_number = AW'(s);
    @(posedge clk); #1;
    start = 1'b0;
    samp_number = AW'(1);
`ifdef DFT_SEQ_PERF_EN
    @(negedge clk);
    chk("perf_cleared_on_start", m_perf, 0);
`endif
    repeat (dl_delay - 1) @(posedge clk);
    #1 data_loaded = 1'b1;

    if (noise) begin
      seen = 0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        seen = m_acc_clr;
      end
      chk("noise_wait_aclr", seen, 1);
      for (int i = 0; i < 2 * s; i++) begin
        @(posedge clk); #1;
        start = ~start;
        out_done = ~out_done;
        samp_number = AW'(2 + i);
      end
      start = 1'b0;
      out_done = 1'b0;
    end

    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      seen = m_calc_end;
    end
    chk("calc_end_timeout", seen, 1);
    if (seen) begin
`ifdef DFT_SEQ_PERF_EN
      chk("perf_in_done", m_perf, s * (s + ml + 2));
`endif
      repeat (od_delay) @(posedge clk);
      #1 out_done = 1'b1;
      @(posedge clk);
      #1 out_done = 1'b0;
    end
    data_loaded = 1'b0;
    @(negedge clk);
    chk("idle_after_done_busy", m_busy, 0);
    chk("idle_after_done_calc_end", m_calc_end, 0);
  endtask

  initial begin
    bit seen;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // Too-short lengths are rejected with one err_len pulse each.
    for (int t = 0; t < 2; t++) begin
      exp_err_q.push_back(1);
      @(posedge clk); #1;
      start = 1'b1;
      samp_number = AW'(1 - t);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("reject_busy", m_busy, 0);
      end
    end
    chk("reject_err_seen", exp_err_q.size(), 0);

    // Reset in the middle of ACC, S=8.
    for (int i = 0; i < 8; i++) exp_fill_q.push_back(i);
    @(posedge clk); #1;
    start = 1'b1;
    samp_number = AW'(8);
    @(posedge clk); #1;
    start = 1'b0;
    data_loaded = 1'b1;
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = m_acc_en;
    end
    chk("reset_wait_acc_en", seen, 1);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    data_loaded = 1'b0;
    @(negedge clk);
    chk_idle("midrun_reset");
    chk("midrun_fill_consumed", exp_fill_q.size(), 0);

    sel = 1'b0;
    do_run(4, 2, 3, 5, 1'b0);
    sel = 1'b1;
    do_run(2, 0, 1, 2, 1'b0);
    sel = 1'b0;
    do_run(3, 2, 2, 1, 1'b1);
    do_run(4, 2, 1, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("end_fill_q_empty", exp_fill_q.size(), 0);
    chk("end_res_q_empty", exp_res_q.size(), 0);
    chk("end_sum_q_empty", exp_sum_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
